// File: rtl/posit_multiplier.sv
// posit<N,ES> multiplier: decode both operands, multiply mantissas, re-encode with
// round-to-nearest-even and saturation, and register the product.
module posit_multiplier #(
  parameter  int N  = 32,
  parameter  int ES = 4,
  localparam int RS = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic [N-1:0] OUT
);

  localparam int MW = N - ES;         // mantissa width including hidden bit
  localparam int PW = 2 * MW;         // full product width
  localparam int NF = PW - 1;         // fraction width after normalisation
  localparam int SW = RS + ES + 3;    // signed scale width
  localparam int BW = 2 + ES + NF;    // regime seed + exponent + fraction
  localparam int TW = BW + N;         // room for the regime shift without loss

  localparam logic [N-1:0]          NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]          MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]          MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]  KMAX_S = SW'(N - 2);
  localparam logic signed [SW-1:0]  KMIN_S = SW'(2 - N);
  localparam logic [RS-1:0]         M_ONE  = RS'(1);

  typedef struct packed {
    logic                 sgn;
    logic signed [SW-1:0] scale;
    logic [MW-1:0]        mant;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] w);
    dec_t                 d;
    logic [N-2:0]         rem_s;
    logic [N-2:0]         tail_s;
    logic                 run_bit_s;
    logic                 in_run_s;
    logic [RS-1:0]        m_s;
    logic signed [SW-1:0] k_s;
    d.sgn     = w[N-1];
    rem_s     = w[N-1] ? -w[N-2:0] : w[N-2:0];
    run_bit_s = rem_s[N-2];
    in_run_s  = 1'b1;
    m_s       = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (in_run_s && (rem_s[i] == run_bit_s)) begin
        m_s = m_s + M_ONE;
      end else begin
        in_run_s = 1'b0;
      end
    end
    k_s     = run_bit_s ? (SW'(m_s) - SW'(1)) : -SW'(m_s);
    // drop the run and its terminator; exponent bits past the lsb read as zero
    tail_s  = (rem_s << m_s) << 1'b1;
    d.scale = (k_s <<< ES) + SW'(tail_s[N-2 -: ES]);
    d.mant  = {1'b1, tail_s[N-2-ES:0]};
    return d;
  endfunction

  dec_t                 da_s;
  dec_t                 db_s;
  logic                 sgn_s;
  logic [PW-1:0]        prod_s;
  logic [NF-1:0]        frac_s;
  logic signed [SW-1:0] scale_s;
  logic signed [SW-1:0] k_s;
  logic [ES-1:0]        e_s;
  logic [BW-1:0]        body_s;
  logic [RS-1:0]        sh_s;
  logic [TW-1:0]        wide_s;
  logic [N-2:0]         top_s;
  logic                 guard_s;
  logic                 sticky_s;
  logic                 round_s;
  logic [N-2:0]         mag_s;
  logic [N-1:0]         sel_s;
  logic [N-1:0]         res_s;

  // Decode, multiply and lay out the regime/exponent/fraction string.
  always_comb begin
    da_s    = decode(IN1);
    db_s    = decode(IN2);
    sgn_s   = da_s.sgn ^ db_s.sgn;
    prod_s  = PW'(da_s.mant) * PW'(db_s.mant);
    scale_s = da_s.scale + db_s.scale + SW'(prod_s[PW-1]);
    frac_s  = prod_s[PW-1] ? prod_s[PW-2:0] : {prod_s[PW-3:0], 1'b0};
    k_s     = scale_s >>> ES;
    e_s     = scale_s[ES-1:0];
    // seed "10" sign-extends to k+1 ones; seed "01" shifts in -k zeros before the 1
    if (k_s[SW-1]) begin
      body_s = {2'b01, e_s, frac_s};
      sh_s   = RS'(-k_s - SW'(1));
    end else begin
      body_s = {2'b10, e_s, frac_s};
      sh_s   = RS'(k_s);
    end
    wide_s   = $signed({body_s, {N{1'b0}}}) >>> sh_s;
    top_s    = wide_s[TW-1 -: N-1];
    guard_s  = wide_s[TW-N];
    sticky_s = |wide_s[TW-N-1:0];
    round_s  = guard_s & (sticky_s | top_s[0]);
    mag_s    = top_s + {{(N-2){1'b0}}, round_s};
  end

  // Specials, saturation and sign application.
  always_comb begin
    sel_s = '0;
    res_s = '0;
    if ((IN1 == NAR) || (IN2 == NAR)) begin
      res_s = NAR;
    end else if ((IN1 == '0) || (IN2 == '0)) begin
      res_s = '0;
    end else begin
      if (k_s > KMAX_S) begin
        sel_s = MAXPOS;
      end else if (k_s < KMIN_S) begin
        sel_s = MINPOS;
      end else begin
        sel_s = {1'b0, mag_s};
      end
      res_s = sgn_s ? -sel_s : sel_s;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT <= '0;
    end else begin
      OUT <= res_s;
    end
  end

endmodule

// File: tb/tb_posit_multiplier.sv
// Bench for posit_multiplier: directed vector table, reset/back-to-back sequences and
// random operands checked against a value-level posit<32,4> reference.
module tb_posit_multiplier;

  localparam int ES = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] out;

  int n_pass;
  int n_total;

  posit_multiplier dut (
    .clk  (clk),
    .rst_n(rst_n),
    .IN1  (in1),
    .IN2  (in2),
    .OUT  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Decode a positive posit of width w into scale and a left-aligned fraction.
  function automatic void pdec(input logic [63:0] p, input int w,
                               output int scale, output logic [63:0] fr);
    int   i, m, k, e, pos;
    logic b;
    i = w - 2;
    b = p[i];
    m = 0;
    while (i >= 0) begin
      if (p[i] != b) break;
      m++;
      i--;
    end
    k = b ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(p[i]) : 0);
      i--;
    end
    fr  = '0;
    pos = 63;
    while (i >= 0) begin
      fr[pos] = p[i];
      pos--;
      i--;
    end
    scale = k * (1 << ES) + e;
  endfunction

  function automatic int cmpv(input int sa, input logic [63:0] fa,
                              input int sb, input logic [63:0] fb);
    if (sa < sb) return -1;
    if (sa > sb) return 1;
    if (fa < fb) return -1;
    if (fa > fb) return 1;
    return 0;
  endfunction

  // Exact product, then nearest posit by search; ties resolved via the 33-bit midpoint.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, lo, hi, mid, mag;
    logic [63:0] fa, fb, fx, ft, pm;
    int          sa, sb, sx, st, c;
    if (a == 32'h80000000 || b == 32'h80000000) return 32'h80000000;
    if (a == 32'h00000000 || b == 32'h00000000) return 32'h00000000;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    pdec({32'h0, ma}, 32, sa, fa);
    pdec({32'h0, mb}, 32, sb, fb);
    pm = {36'h0, 1'b1, fa[63:37]} * {36'h0, 1'b1, fb[63:37]};
    if (pm[55]) begin
      sx = sa + sb + 1;
      fx = pm << 9;
    end else begin
      sx = sa + sb;
      fx = pm << 10;
    end
    pdec({32'h0, 32'h7FFFFFFF}, 32, st, ft);
    if (cmpv(sx, fx, st, ft) >= 0) begin
      mag = 32'h7FFFFFFF;
    end else begin
      pdec({32'h0, 32'h00000001}, 32, st, ft);
      if (cmpv(sx, fx, st, ft) <= 0) begin
        mag = 32'h00000001;
      end else begin
        lo = 32'h00000001;
        hi = 32'h7FFFFFFF;
        while (hi - lo > 32'd1) begin
          mid = lo + ((hi - lo) >> 1);
          pdec({32'h0, mid}, 32, st, ft);
          if (cmpv(st, ft, sx, fx) <= 0) lo = mid;
          else hi = mid;
        end
        pdec({32'h0, lo}, 32, st, ft);
        if (cmpv(sx, fx, st, ft) == 0) begin
          mag = lo;
        end else begin
          pdec({31'h0, lo, 1'b1}, 33, st, ft);
          c = cmpv(sx, fx, st, ft);
          if (c > 0) mag = lo + 32'd1;
          else if (c < 0) mag = lo;
          else mag = lo[0] ? lo + 32'd1 : lo;
        end
      end
    end
    return (a[31] ^ b[31]) ? -mag : mag;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int          mode;
    mode = $urandom_range(0, 7);
    if (mode == 0) begin
      v = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h00000000;
    end else if (mode <= 3) begin
      v = 32'h40000000 ^ ($urandom >> 4);
    end else if (mode == 4) begin
      v = $urandom >> $urandom_range(20, 30);
    end else if (mode == 5) begin
      v = 32'h7FFFFFFF ^ ($urandom >> $urandom_range(20, 30));
    end else begin
      v = $urandom;
    end
    if (mode != 0 && $urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  vec_t        tbl [0:14];
  logic [31:0] ra, rb, rexp, prev_exp;

  initial begin
    n_pass  = 0;
    n_total = 0;
    tbl = '{
      '{32'h00000000, 32'h00000000, 32'h00000000},
      '{32'h00000000, 32'h54AAA545, 32'h00000000},
      '{32'h80000000, 32'hA92AA456, 32'h80000000},
      '{32'h4954A722, 32'h80000000, 32'h80000000},
      '{32'h80000000, 32'h00000000, 32'h80000000},
      '{32'h40000000, 32'h40000000, 32'h40000000},
      '{32'h42000000, 32'h42000000, 32'h44000000},
      '{32'h41000000, 32'h41000000, 32'h42400000},
      '{32'h60000000, 32'h60000000, 32'h70000000},
      '{32'hC0000000, 32'h42000000, 32'hBE000000},
      '{32'hC0000000, 32'hC0000000, 32'h40000000},
      '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{32'h00000001, 32'h00000001, 32'h00000001},
      '{32'h80000001, 32'h7FFFFFFF, 32'h80000001},
      '{32'h40000001, 32'h40000001, 32'h40000002}
    };

    rst_n = 1'b0;
    in1   = 32'h42000000;
    in2   = 32'h42000000;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", out, 32'h00000000);

    @(negedge clk);
    rst_n = 1'b1;
    in1   = 32'h40000000;
    in2   = 32'h42000000;
    @(posedge clk);
    #1 check("first_after_reset", out, 32'h42000000);

    // reset asserted between edges clears OUT immediately
    @(negedge clk);
    in1 = 32'h60000000;
    in2 = 32'h60000000;
    @(posedge clk);
    #1 check("pre_reset", out, 32'h70000000);
    #2 rst_n = 1'b0;
    #1 check("async_reset", out, 32'h00000000);
    @(posedge clk);
    #1 check("reset_blocks_edge", out, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in1 = tbl[i].a;
      in2 = tbl[i].b;
      @(posedge clk);
      #1 check($sformatf("dir[%0d]", i), out, tbl[i].exp);
    end

    // back-to-back: OUT holds the previous product until the next edge
    prev_exp = tbl[14].exp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in1 = tbl[5 + i].a;
      in2 = tbl[5 + i].b;
      #1 check($sformatf("b2b_hold[%0d]", i), out, prev_exp);
      @(posedge clk);
      #1 check($sformatf("b2b[%0d]", i), out, tbl[5 + i].exp);
      prev_exp = tbl[5 + i].exp;
    end

    for (int i = 0; i < 400; i++) begin
      ra   = rand_operand();
      rb   = rand_operand();
      rexp = ref_mul(ra, rb);
      @(negedge clk);
      in1 = ra;
      in2 = rb;
      @(posedge clk);
      #1 check($sformatf("rand[%0d] %h*%h", i, ra, rb), out, rexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
